fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_queue.sv | 64 ++++++
 tb/tb_fetch_queue.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: the reset PC default, the NOP
// word presented when the queue is empty, and the entry layout.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with push/pop/flush. DEPTH is a power of two, so
// the read and write pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fq_entry_t                  push_data,
  output fq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A pop coinciding with a flush needs no separate handling: the head
      // entry is consumed along with everything else.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: the PC drives a combinational instruction memory,
// fetched words are queued, and the head entry is presented to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] count;
  fq_entry_t     head;
  fq_entry_t     push_data;
  logic          pop;
  logic          push;

  assign pop       = id_valid && id_ready;
  // Redirect wins over a fetch in the same cycle.
  assign push      = ((count < CW'(DEPTH)) || pop) && !br_taken;
  assign push_data = '{pc: pc, instr: imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (br_taken) begin
      pc <= {br_target[31:2], 2'b00};
      if (br_target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (br_taken),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign imem_addr = pc;
  assign id_valid  = (count != '0);
  assign id_instr  = id_valid ? head.instr : NOP_INSTR;
  assign id_pc     = id_valid ? head.pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for the main sequence plus
// hand-written async-reset and PC-wrap sequences.
module tb_fetch_queue;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        misalign_err;

  logic        rst2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_instr2, id_pc2;
  logic        misalign_err2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr ^ SALT;
  assign imem_rdata2 = imem_addr2 ^ SALT;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .misalign_err (misalign_err)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk          (clk),
    .rst          (rst2),
    .imem_addr    (imem_addr2),
    .imem_rdata   (imem_rdata2),
    .id_valid     (id_valid2),
    .id_ready     (1'b1),
    .id_instr     (id_instr2),
    .id_pc        (id_pc2),
    .br_taken     (1'b0),
    .br_target    (32'h0000_0000),
    .misalign_err (misalign_err2)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rdy, input logic br,
                              input logic [31:0] tgt, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eaddr,
                              input logic emis);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.ev = ev; v.epc = ev ? epc : 32'h0;
    v.einstr = ev ? (epc ^ SALT) : NOP;
    v.eaddr = eaddr; v.emis = emis;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    id_ready = 1'b1; br_taken = 1'b0; br_target = 32'h0;

    //   rst rdy br  target        valid id_pc         imem_addr     mis
    add(1, 1, 0, 32'h0,        0, 32'h0,       32'h0,        0);  // reset
    add(0, 1, 0, 32'h0,        1, 32'h0,       32'h4,        0);  // reset fetch
    add(0, 1, 0, 32'h0,        1, 32'h4,       32'h8,        0);
    add(0, 1, 0, 32'h0,        1, 32'h8,       32'hC,        0);
    add(1, 0, 0, 32'h0,        0, 32'h0,       32'h0,        0);  // backpressure
    add(0, 0, 0, 32'h0,        1, 32'h0,       32'h4,        0);
    add(0, 0, 0, 32'h0,        1, 32'h0,       32'h8,        0);
    add(0, 0, 0, 32'h0,        1, 32'h0,       32'h8,        0);
    add(0, 0, 0, 32'h0,        1, 32'h0,       32'h8,        0);
    add(0, 0, 0, 32'h0,        1, 32'h0,       32'h8,        0);
    add(0, 1, 0, 32'h0,        1, 32'h4,       32'hC,        0);
    add(0, 1, 0, 32'h0,        1, 32'h8,       32'h10,       0);
    add(0, 1, 1, 32'h100,      0, 32'h0,       32'h100,      0);  // redirect + pop, full
    add(0, 1, 0, 32'h0,        1, 32'h100,     32'h104,      0);
    add(0, 0, 1, 32'h102,      0, 32'h0,       32'h100,      1);  // misaligned
    add(0, 0, 0, 32'h0,        1, 32'h100,     32'h104,      1);
    add(0, 0, 0, 32'h0,        1, 32'h100,     32'h108,      1);
    add(0, 0, 0, 32'h0,        1, 32'h100,     32'h108,      1);
    add(0, 1, 1, 32'h200,      0, 32'h0,       32'h200,      1);  // sticky flag
    add(0, 0, 0, 32'h0,        1, 32'h200,     32'h204,      1);
    add(0, 0, 0, 32'h0,        1, 32'h200,     32'h208,      1);

    @(posedge clk); #1;
    check("reset id_valid", {31'b0, id_valid}, 32'h0);
    check("reset id_instr", id_instr, NOP);
    check("reset imem_addr", imem_addr, 32'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; id_ready = vecs[i].rdy;
      br_taken = vecs[i].br; br_target = vecs[i].tgt;
      @(posedge clk); #1;
      check($sformatf("row%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].ev});
      check($sformatf("row%0d id_pc", i), id_pc, vecs[i].epc);
      check($sformatf("row%0d id_instr", i), id_instr, vecs[i].einstr);
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      check($sformatf("row%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].emis});
    end

    // Async reset between edges with two entries queued.
    id_ready = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async id_valid", {31'b0, id_valid}, 32'h0);
    check("async id_instr", id_instr, NOP);
    check("async id_pc", id_pc, 32'h0);
    check("async imem_addr", imem_addr, 32'h0);
    check("async misalign_err", {31'b0, misalign_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; id_ready = 1'b1;
    @(posedge clk); #1;
    check("post-reset id_valid", {31'b0, id_valid}, 32'h1);
    check("post-reset id_pc", id_pc, 32'h0);
    check("post-reset id_instr", id_instr, SALT);

    // PC wrap from a high reset vector.
    check("wrap reset imem_addr", imem_addr2, 32'hFFFF_FFF8);
    rst2 = 1'b0;
    @(posedge clk); #1;
    check("wrap id_pc 0", id_pc2, 32'hFFFF_FFF8);
    check("wrap id_instr 0", id_instr2, 32'hFFFF_FFF8 ^ SALT);
    @(posedge clk); #1;
    check("wrap id_pc 1", id_pc2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap id_pc 2", id_pc2, 32'h0000_0000);
    check("wrap id_instr 2", id_instr2, SALT);
    check("wrap misalign_err", {31'b0, misalign_err2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
